// File: rtl/controle_botoes_if.sv
// controle_botoes_if: raw button / sequencer signals of the buzzer player control front end
interface controle_botoes_if;
   logic       btn_play;
   logic       btn_stop;
   logic       fim_musica;
   logic       play;
   logic       stop;
   logic [1:0] estado;
   logic       led_tocando;
   modport master (output btn_play, btn_stop, fim_musica, input play, stop, estado, led_tocando);
   modport slave (input btn_play, btn_stop, fim_musica, output play, stop, estado, led_tocando);
endinterface

// File: rtl/controle_botoes.sv
// controle_botoes: debounced PLAY/STOP buttons driving a PARADO/TOCANDO/PAUSADO player FSM
module controle_botoes #(
   parameter int DEBOUNCE_CYCLES = 1_000_000,
   parameter bit BTN_ACTIVE_LOW  = 1'b1
) (
   input logic              Clk,
   input logic              Reset,
   controle_botoes_if.slave bus
);
   localparam int            CW       = $clog2(DEBOUNCE_CYCLES);
   localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);
   localparam logic [1:0]    RELEASED = {2{BTN_ACTIVE_LOW}};
   typedef enum logic [1:0] {PARADO = 2'b00, TOCANDO = 2'b01, PAUSADO = 2'b10} estado_t;
   // bit 0 is PLAY, bit 1 is STOP throughout
   logic [1:0]          raw, pressed;
   logic [1:0]          s1_q, s1_d, s2_q, s2_d, stable_q, stable_d, ev_q, ev_d;
   logic [1:0][CW-1:0]  cnt_q, cnt_d;
   estado_t             state_q, state_d;
   logic                stop_q, stop_d;
   assign raw     = {bus.btn_stop, bus.btn_play};
   assign pressed = BTN_ACTIVE_LOW ? ~s2_q : s2_q;
   // two-flop synchroniser, then a counter that must see DEBOUNCE_CYCLES differing cycles in a row
   always_comb begin
      s1_d     = raw;
      s2_d     = s1_q;
      stable_d = stable_q;
      cnt_d    = cnt_q;
      ev_d     = '0;
      for (int i = 0; i < 2; i++) begin
         if (pressed[i] == stable_q[i]) cnt_d[i] = '0;
         else if (cnt_q[i] == CNT_LAST) begin
            stable_d[i] = pressed[i];
            cnt_d[i]    = '0;
            ev_d[i]     = pressed[i];
         end else cnt_d[i] = cnt_q[i] + CW'(1);
      end
   end
   // player state: stop beats end-of-song beats play toggle
   always_comb begin
      state_d = state_q;
      stop_d  = ev_q[1];
      if (ev_q[1]) state_d = PARADO;
      else if (bus.fim_musica && state_q == TOCANDO) state_d = PARADO;
      else if (ev_q[0]) state_d = (state_q == TOCANDO) ? PAUSADO : TOCANDO;
   end
   // all state registers, synchronous reset to idle with buttons released
   always_ff @(posedge Clk) begin
      if (Reset) begin
         s1_q     <= RELEASED;
         s2_q     <= RELEASED;
         stable_q <= '0;
         cnt_q    <= '0;
         ev_q     <= '0;
         state_q  <= PARADO;
         stop_q   <= 1'b0;
      end else begin
         s1_q     <= s1_d;
         s2_q     <= s2_d;
         stable_q <= stable_d;
         cnt_q    <= cnt_d;
         ev_q     <= ev_d;
         state_q  <= state_d;
         stop_q   <= stop_d;
      end
   end
   assign bus.play        = (state_q == TOCANDO);
   assign bus.led_tocando = (state_q == TOCANDO);
   assign bus.estado      = state_q;
   assign bus.stop        = stop_q;
endmodule
